// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a request/ready data bus through a
// three-state FSM and forms the register-write triple for MEM/WB.

package mem_access_pkg;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LBU = 8'h21;
    localparam logic [7:0] OP_LH  = 8'h22;
    localparam logic [7:0] OP_LHU = 8'h23;
    localparam logic [7:0] OP_LW  = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2A;
endpackage

module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           mem_instruction,
    input  logic [7:0]            mem_operator,
    input  logic [31:0]           mem_operand_a,
    input  logic [31:0]           mem_operand_b,
    input  logic                  mem_reg_write_enable,
    input  logic [4:0]            mem_reg_write_address,
    input  logic [31:0]           mem_reg_write_data,
    input  logic                  stall_hold,
    output logic                  wb_reg_write_enable,
    output logic [4:0]            wb_reg_write_address,
    output logic [31:0]           wb_reg_write_data,
    output logic                  stall_request,
    output logic                  misaligned,
    output logic                  bus_request,
    output logic                  bus_write,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [3:0]            bus_byte_select,
    output logic [31:0]           bus_write_data,
    input  logic [31:0]           bus_read_data,
    input  logic                  bus_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic                  bus_request_q, bus_request_d;
    logic                  bus_write_q, bus_write_d;
    logic [ADDR_WIDTH-1:0] bus_address_q, bus_address_d;
    logic [3:0]            bus_byte_select_q, bus_byte_select_d;
    logic [31:0]           bus_write_data_q, bus_write_data_d;
    logic [31:0]           load_q, load_d;

    logic       is_load, is_store, is_mem, is_byte, is_half, is_word, is_signed;
    logic [1:0] addr_lo;
    logic [3:0] lanes;
    logic [31:0] store_rep, load_ext;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        unused_bits;

    assign unused_bits = ^{mem_instruction, mem_operand_a};
    assign addr_lo     = mem_operand_a[1:0];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (mem_operator)
            OP_LB:  begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU: begin is_load = 1'b1; is_byte = 1'b1; end
            OP_LH:  begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW:  begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = is_mem & ((is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00)));

    // Big-endian lanes: byte 0 of the word lives on bits [31:24] (lane bit 3).
    always_comb begin
        lanes     = 4'b1111;
        store_rep = mem_operand_b;
        if (is_byte) begin
            lanes     = 4'b1000 >> addr_lo;
            store_rep = {4{mem_operand_b[7:0]}};
        end else if (is_half) begin
            lanes     = addr_lo[1] ? 4'b0011 : 4'b1100;
            store_rep = {2{mem_operand_b[15:0]}};
        end
    end

    always_comb begin
        case (addr_lo)
            2'd0:    load_byte = load_q[31:24];
            2'd1:    load_byte = load_q[23:16];
            2'd2:    load_byte = load_q[15:8];
            default: load_byte = load_q[7:0];
        endcase
        load_half = addr_lo[1] ? load_q[15:0] : load_q[31:16];
        if (is_byte)
            load_ext = {{24{is_signed & load_byte[7]}}, load_byte};
        else if (is_half)
            load_ext = {{16{is_signed & load_half[15]}}, load_half};
        else
            load_ext = load_q;
    end

    always_comb begin
        state_d           = state_q;
        bus_request_d     = bus_request_q;
        bus_write_d       = bus_write_q;
        bus_address_d     = bus_address_q;
        bus_byte_select_d = bus_byte_select_q;
        bus_write_data_d  = bus_write_data_q;
        load_d            = load_q;
        case (state_q)
            IDLE: begin
                if (is_mem && !misaligned) begin
                    state_d           = BUSY;
                    bus_request_d     = 1'b1;
                    bus_write_d       = is_store;
                    bus_address_d     = {mem_operand_a[ADDR_WIDTH-1:2], 2'b00};
                    bus_byte_select_d = lanes;
                    bus_write_data_d  = store_rep;
                end
            end
            BUSY: begin
                if (bus_ready) begin
                    state_d       = DONE;
                    bus_request_d = 1'b0;
                    if (is_load)
                        load_d = bus_read_data;
                end
            end
            DONE: begin
                if (!stall_hold)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            bus_request_q     <= 1'b0;
            bus_write_q       <= 1'b0;
            bus_address_q     <= '0;
            bus_byte_select_q <= 4'b0000;
            bus_write_data_q  <= 32'h0;
            load_q            <= 32'h0;
        end else begin
            state_q           <= state_d;
            bus_request_q     <= bus_request_d;
            bus_write_q       <= bus_write_d;
            bus_address_q     <= bus_address_d;
            bus_byte_select_q <= bus_byte_select_d;
            bus_write_data_q  <= bus_write_data_d;
            load_q            <= load_d;
        end
    end

    assign bus_request     = bus_request_q;
    assign bus_write       = bus_write_q;
    assign bus_address     = bus_address_q;
    assign bus_byte_select = bus_byte_select_q;
    assign bus_write_data  = bus_write_data_q;

    assign stall_request = (state_q == BUSY) || (state_q == IDLE && is_mem && !misaligned);

    // Memory ops only write back from DONE, and only for loads.
    always_comb begin
        wb_reg_write_address = mem_reg_write_address;
        wb_reg_write_enable  = mem_reg_write_enable;
        wb_reg_write_data    = mem_reg_write_data;
        if (is_mem) begin
            wb_reg_write_enable = (state_q == DONE) && is_load && mem_reg_write_enable;
            if (state_q == DONE && is_load)
                wb_reg_write_data = load_ext;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table for single-cycle
// behaviour plus hand-written multi-cycle load/store/reset/hold sequences.

module tb_mem_access_stage;
    import mem_access_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_instruction;
    logic [7:0]  mem_operator;
    logic [31:0] mem_operand_a, mem_operand_b;
    logic        mem_reg_write_enable;
    logic [4:0]  mem_reg_write_address;
    logic [31:0] mem_reg_write_data;
    logic        stall_hold;
    logic        wb_reg_write_enable;
    logic [4:0]  wb_reg_write_address;
    logic [31:0] wb_reg_write_data;
    logic        stall_request, misaligned;
    logic        bus_request, bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_select;
    logic [31:0] bus_write_data, bus_read_data;
    logic        bus_ready;

    int passed = 0;
    int total  = 0;

    mem_access_stage #(.ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .mem_instruction(mem_instruction), .mem_operator(mem_operator),
        .mem_operand_a(mem_operand_a), .mem_operand_b(mem_operand_b),
        .mem_reg_write_enable(mem_reg_write_enable),
        .mem_reg_write_address(mem_reg_write_address),
        .mem_reg_write_data(mem_reg_write_data),
        .stall_hold(stall_hold),
        .wb_reg_write_enable(wb_reg_write_enable),
        .wb_reg_write_address(wb_reg_write_address),
        .wb_reg_write_data(wb_reg_write_data),
        .stall_request(stall_request), .misaligned(misaligned),
        .bus_request(bus_request), .bus_write(bus_write),
        .bus_address(bus_address), .bus_byte_select(bus_byte_select),
        .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
        .bus_ready(bus_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
        mem_instruction       = 32'h0000_0013;
        mem_operator          = op;
        mem_operand_a         = a;
        mem_operand_b         = b;
        mem_reg_write_enable  = we;
        mem_reg_write_address = wa;
        mem_reg_write_data    = wd;
    endtask

    task automatic set_nop();
        set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Issue one aligned memory op starting in IDLE at a negedge and walk it to
    // IDLE again. Expectations are supplied by the caller.
    task automatic run_mem(input string nm, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int delay, input logic [31:0] rdata,
                           input int hold, input logic [31:0] e_addr, input logic [3:0] e_lanes,
                           input logic e_write, input logic [31:0] e_wdata,
                           input logic e_wben, input logic [31:0] e_wbdata);
        set_op(op, a, b, 1'b1, 5'd9, 32'h5555_5555);
        bus_ready = 1'b0;
        #1;
        chk({nm, " idle stall"}, 32'(stall_request), 32'd1);
        chk({nm, " idle wb_en"}, 32'(wb_reg_write_enable), 32'd0);
        chk({nm, " idle no req"}, 32'(bus_request), 32'd0);
        for (int i = 0; i <= delay; i++) begin
            @(negedge clock);
            chk({nm, " busy req"}, 32'(bus_request), 32'd1);
            chk({nm, " busy stall"}, 32'(stall_request), 32'd1);
            chk({nm, " busy addr"}, bus_address, e_addr);
            chk({nm, " busy lanes"}, 32'(bus_byte_select), 32'(e_lanes));
            chk({nm, " busy write"}, 32'(bus_write), 32'(e_write));
            if (e_write) chk({nm, " busy wdata"}, bus_write_data, e_wdata);
            if (i == delay) begin
                bus_ready     = 1'b1;
                bus_read_data = rdata;
            end
        end
        @(negedge clock);
        bus_ready     = 1'b0;
        bus_read_data = 32'h0;
        stall_hold    = (hold > 0);
        #1;
        chk({nm, " done stall"}, 32'(stall_request), 32'd0);
        chk({nm, " done req"}, 32'(bus_request), 32'd0);
        chk({nm, " done wb_en"}, 32'(wb_reg_write_enable), 32'(e_wben));
        if (e_wben) chk({nm, " done wb_data"}, wb_reg_write_data, e_wbdata);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk({nm, " hold wb_en"}, 32'(wb_reg_write_enable), 32'(e_wben));
            chk({nm, " hold wb_data"}, wb_reg_write_data, e_wbdata);
            chk({nm, " hold stall"}, 32'(stall_request), 32'd0);
            if (h == hold - 1) stall_hold = 1'b0;
        end
        set_nop();
        @(negedge clock);
        chk({nm, " back idle req"}, 32'(bus_request), 32'd0);
        chk({nm, " back idle stall"}, 32'(stall_request), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] a;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_wben;
        logic [31:0] e_wbdata;
        logic        e_stall;
        logic        e_mis;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"nop pass",  OP_NOP, 32'h0,   1'b1, 5'd5,  32'h0000_1234, 1'b1, 32'h0000_1234, 1'b0, 1'b0};
        vecs[1] = '{"alu no we", 8'h01,  32'h104, 1'b0, 5'd7,  32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0};
        vecs[2] = '{"lw 101",    OP_LW,  32'h101, 1'b1, 5'd3,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
        vecs[3] = '{"lw 102",    OP_LW,  32'h102, 1'b1, 5'd3,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
        vecs[4] = '{"lh 103",    OP_LH,  32'h103, 1'b1, 5'd4,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
        vecs[5] = '{"sh 201",    OP_SH,  32'h201, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
        vecs[6] = '{"sw 203",    OP_SW,  32'h203, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1};

        reset = 1'b1; stall_hold = 1'b0; bus_ready = 1'b0; bus_read_data = 32'h0;
        set_nop();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset req",   32'(bus_request), 32'd0);
        chk("reset write", 32'(bus_write), 32'd0);
        chk("reset addr",  bus_address, 32'h0);
        chk("reset lanes", 32'(bus_byte_select), 32'd0);
        chk("reset wdata", bus_write_data, 32'h0);
        chk("reset stall", 32'(stall_request), 32'd0);

        foreach (vecs[i]) begin
            @(negedge clock);
            set_op(vecs[i].op, vecs[i].a, 32'hFFFF_FFFF, vecs[i].we, vecs[i].wa, vecs[i].wd);
            #1;
            chk({vecs[i].name, " wb_en"}, 32'(wb_reg_write_enable), 32'(vecs[i].e_wben));
            chk({vecs[i].name, " wb_addr"}, 32'(wb_reg_write_address), 32'(vecs[i].wa));
            if (vecs[i].e_wben) chk({vecs[i].name, " wb_data"}, wb_reg_write_data, vecs[i].e_wbdata);
            chk({vecs[i].name, " stall"}, 32'(stall_request), 32'(vecs[i].e_stall));
            chk({vecs[i].name, " misaligned"}, 32'(misaligned), 32'(vecs[i].e_mis));
            @(negedge clock);
            chk({vecs[i].name, " no req"}, 32'(bus_request), 32'd0);
            chk({vecs[i].name, " still no stall"}, 32'(stall_request), 32'd0);
        end
        @(negedge clock);
        set_nop();
        @(negedge clock);

        //       name    op      addr     opb            dly rdata          hold e_addr   lanes    wr    wdata          wben  wbdata
        run_mem("lw",  OP_LW,  32'h100, 32'h0,         0, 32'hDEAD_BEEF, 0, 32'h100, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF);
        run_mem("lb",  OP_LB,  32'h103, 32'h0,         0, 32'h0000_00F0, 0, 32'h100, 4'b0001, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF0);
        run_mem("lbu", OP_LBU, 32'h103, 32'h0,         1, 32'h0000_00F0, 0, 32'h100, 4'b0001, 1'b0, 32'h0,         1'b1, 32'h0000_00F0);
        run_mem("lhu", OP_LHU, 32'h100, 32'h0,         0, 32'h8765_4321, 0, 32'h100, 4'b1100, 1'b0, 32'h0,         1'b1, 32'h0000_8765);
        run_mem("lb1", OP_LB,  32'h105, 32'h0,         0, 32'h1280_3456, 0, 32'h104, 4'b0100, 1'b0, 32'h0,         1'b1, 32'hFFFF_FF80);
        run_mem("sh",  OP_SH,  32'h202, 32'h0000_ABCD, 3, 32'h0,         0, 32'h200, 4'b0011, 1'b1, 32'hABCD_ABCD, 1'b0, 32'h0);
        run_mem("sb",  OP_SB,  32'h301, 32'h1234_565A, 0, 32'h0,         0, 32'h300, 4'b0100, 1'b1, 32'h5A5A_5A5A, 1'b0, 32'h0);
        run_mem("sw",  OP_SW,  32'h400, 32'hCAFE_F00D, 2, 32'h0,         0, 32'h400, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0);
        run_mem("lh hold", OP_LH, 32'h102, 32'h0,      0, 32'h1234_8765, 3, 32'h100, 4'b0011, 1'b0, 32'h0,         1'b1, 32'hFFFF_8765);

        // Reset while the bus access is still outstanding.
        set_op(OP_LW, 32'h500, 32'h0, 1'b1, 5'd2, 32'h0);
        @(negedge clock);
        chk("rst busy req", 32'(bus_request), 32'd1);
        reset = 1'b1;
        set_nop();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst after req", 32'(bus_request), 32'd0);
        chk("rst after stall", 32'(stall_request), 32'd0);
        chk("rst after lanes", 32'(bus_byte_select), 32'd0);
        // A fresh op must be detected from IDLE, not carried on from BUSY.
        set_op(OP_LW, 32'h600, 32'h0, 1'b1, 5'd2, 32'h0);
        #1;
        chk("rst reissue no req", 32'(bus_request), 32'd0);
        chk("rst reissue stall", 32'(stall_request), 32'd1);
        @(negedge clock);
        chk("rst reissue req", 32'(bus_request), 32'd1);
        chk("rst reissue addr", bus_address, 32'h600);
        bus_ready = 1'b1; bus_read_data = 32'h0BAD_F00D;
        @(negedge clock);
        bus_ready = 1'b0;
        chk("rst reissue data", wb_reg_write_data, 32'h0BAD_F00D);
        set_nop();
        @(negedge clock);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs (instruction, operator, operands, register-write triple).
- Performs loads and stores over a request/ready data-memory bus, with a small FSM.
- Holds the pipeline through the control unit's stall_request while an access is in flight.
- Produces the register-write triple consumed by the MEM/WB register.

Parameters:
- ADDR_WIDTH, 32, width of bus_address (low bits of operand_a are used).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mem_instruction  input  32  instruction word; not decoded here
- mem_operator  input  8  operation code; memory ops are OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW; all other codes are non-memory
- mem_operand_a  input  32  effective address, computed in EX
- mem_operand_b  input  32  store data; low byte/half used for SB/SH
- mem_reg_write_enable  input  1  write enable from EX
- mem_reg_write_address  input  5  destination register
- mem_reg_write_data  input  32  ALU result for non-load ops
- stall_hold  input  1  stall[3] from control; MEM/WB is frozen
- wb_reg_write_enable  output  1  to MEM/WB
- wb_reg_write_address  output  5  to MEM/WB
- wb_reg_write_data  output  32  to MEM/WB
- stall_request  output  1  to control; freezes PC..EX/MEM
- misaligned  output  1  combinational flag; access was suppressed
- bus_request  output  1  registered; memory access pending
- bus_write  output  1  registered; 1 = store
- bus_address  output  ADDR_WIDTH  registered; word-aligned (low 2 bits zero)
- bus_byte_select  output  4  registered byte lanes; bit3 = bits[31:24]
- bus_write_data  output  32  registered; store data replicated onto the selected lanes
- bus_read_data  input  32  valid when bus_ready=1
- bus_ready  input  1  access complete this cycle

Behaviour:
- Reset values:
  - FSM state = IDLE.
  - bus_request, bus_write, bus_address, bus_byte_select, bus_write_data are all 0.
  - Load capture register is 0.
  - Reset mid-access drops bus_request on the reset edge. The bus is expected to discard the access.
- Byte order is big-endian. Byte at addr[1:0]=0 sits on lane bits[31:24].
  - SB: the lane is selected by addr[1:0]; data is replicated 4x.
  - SH: lanes 1100 (addr[1]=0) or 0011; data is replicated 2x.
  - SW: lanes 1111.
  - Loads use the same lane selects.
- Misalignment:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, asserts misaligned.
  - The FSM stays in IDLE and no bus access is made.
  - wb_reg_write_enable is forced to 0, and stall_request is 0.
- States:
  - IDLE:
    - An aligned memory op asserts stall_request, registers the bus signals with bus_request=1, and goes to BUSY.
    - A non-memory op passes mem_reg_write_* straight through to wb_*; stall_request=0.
  - BUSY:
    - bus_* are held stable and stall_request=1.
    - On bus_ready=1: capture bus_read_data (loads), clear bus_request at the edge, go to DONE.
    - bus_ready=0 keeps the FSM in BUSY indefinitely.
  - DONE:
    - stall_request=0.
    - Loads: wb_reg_write_data is the selected byte/half, sign-extended for LB/LH and zero-extended for LBU/LHU, or the full word for LW; wb_reg_write_enable = mem_reg_write_enable.
    - Stores: wb_reg_write_enable=0.
    - stall_hold=1 stays in DONE; stall_hold=0 goes to IDLE.
- Outside DONE, a memory op presents wb_reg_write_enable=0.
- bus_ready is ignored outside BUSY.
- Minimum latency per memory op is 3 cycles: IDLE detect, BUSY, DONE. The stall covers the first two cycles.
- Back-to-back memory ops: the new op is detected in IDLE in the cycle after DONE. The DONE state prevents re-issuing the same op.
- A non-memory op adds 0 cycles. wb_* are combinational from the inputs.

Test Plan:
- ALU op OP_NOP-class, write_enable=1, addr=5, data=0x1234 -> wb_* = (1, 5, 0x1234) same cycle; stall_request=0; bus_request stays 0.
- LW at 0x100, bus_ready on the first BUSY cycle, read 0xDEADBEEF -> bus_address=0x100, lanes=1111; stall high for 2 cycles; DONE gives wb_reg_write_data=0xDEADBEEF.
- LB at 0x103, read 0x000000F0 -> lanes 0001, wb data 0xFFFFFFF0. LBU at the same address -> 0x000000F0.
- SH at 0x202, operand_b 0x0000ABCD, bus_ready delayed 3 cycles -> bus_write=1, address 0x200, lanes 0011, data 0xABCDABCD held constant 4 cycles; wb_reg_write_enable=0 in DONE.
- LW at 0x101 -> misaligned=1, no bus_request, stall_request=0, wb_reg_write_enable=0.
- Reset asserted in BUSY -> next cycle state IDLE, bus_request=0, stall_request=0. In a separate run, stall_hold=1 in DONE keeps load data on wb_* until it is released.
